// File: rtl/uart_pw_lock.sv
// uart_pw_lock: sequential password checker fed by a UART receiver.
// Collects characters up to TERM_CHAR and compares them position by position
// against PASSWORD. On a match it raises unlock. On a mismatch it pulses
// fail_pulse and counts the failure. MAX_FAIL consecutive failures start a
// lockout that lasts LOCK_CYCLES cycles.
// Optional feature macro: UART_PW_BACKSPACE_EN. When it is defined, 8'h08
// deletes the last collected character.
module uart_pw_lock #(
  parameter int                  PW_LEN      = 4,
  parameter logic [PW_LEN*8-1:0] PASSWORD    = 32'h31323334,
  parameter logic [7:0]          TERM_CHAR   = 8'h0D,
  parameter logic [7:0]          RELOCK_CHAR = 8'h1B,
  parameter int                  MAX_FAIL    = 3,
  parameter int                  LOCK_CYCLES = 100000000
) (
  input  logic                            clkin,
  input  logic                            rst_n,
  input  logic [7:0]                      rx_byte,
  input  logic                            rx_valid,
  output logic                            unlock,
  output logic                            fail_pulse,
  output logic                            locked_out,
  output logic [$clog2(PW_LEN+1)-1:0]     char_cnt,
  output logic [$clog2(MAX_FAIL+1)-1:0]   fail_cnt
);

  localparam int CW = $clog2(PW_LEN + 1);
  localparam int FW = $clog2(MAX_FAIL + 1);
  // A one-cycle lockout still needs a one-bit timer.
  localparam int TW = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  localparam logic [CW-1:0] PW_LEN_C  = CW'(PW_LEN);
  localparam logic [FW-1:0] FAIL_LAST = FW'(MAX_FAIL - 1);
  localparam logic [TW-1:0] LOCK_LOAD = TW'(LOCK_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_COLLECT  = 2'd0,
    ST_UNLOCKED = 2'd1,
    ST_LOCKOUT  = 2'd2
  } state_t;

  state_t              state_r;
  logic [PW_LEN-1:0]   match_r;
  logic                overflow_r;
  logic [TW-1:0]       timer_r;
  logic                pass_s;

  // Return password character k. Character 0 sits in the most significant byte.
  function automatic logic [7:0] pw_char(input int k);
    return PASSWORD[(PW_LEN-1-k)*8 +: 8];
  endfunction

  // An attempt passes only with exactly PW_LEN characters, all of them correct.
  assign pass_s = (char_cnt == PW_LEN_C) && (&match_r) && !overflow_r;

  // Main controller: collect/evaluate, unlocked hold, and timed lockout.
  always_ff @(posedge clkin) begin
    if (!rst_n) begin
      state_r    <= ST_COLLECT;
      unlock     <= 1'b0;
      fail_pulse <= 1'b0;
      locked_out <= 1'b0;
      char_cnt   <= {CW{1'b0}};
      fail_cnt   <= {FW{1'b0}};
      match_r    <= {PW_LEN{1'b0}};
      overflow_r <= 1'b0;
      timer_r    <= {TW{1'b0}};
    end else begin
      fail_pulse <= 1'b0;
      case (state_r)
        ST_COLLECT: begin
          if (rx_valid) begin
            if (rx_byte == TERM_CHAR) begin
              char_cnt   <= {CW{1'b0}};
              match_r    <= {PW_LEN{1'b0}};
              overflow_r <= 1'b0;
              if (pass_s) begin
                state_r  <= ST_UNLOCKED;
                unlock   <= 1'b1;
                fail_cnt <= {FW{1'b0}};
              end else begin
                fail_pulse <= 1'b1;
                fail_cnt   <= fail_cnt + 1'b1;
                if (fail_cnt == FAIL_LAST) begin
                  state_r    <= ST_LOCKOUT;
                  locked_out <= 1'b1;
                  timer_r    <= LOCK_LOAD;
                end
              end
            end
`ifdef UART_PW_BACKSPACE_EN
            else if (rx_byte == 8'h08) begin
              // An overflowed attempt is already lost, so backspace cannot rescue it.
              if (!overflow_r && (char_cnt != {CW{1'b0}})) begin
                char_cnt <= char_cnt - 1'b1;
                for (int k = 0; k < PW_LEN; k++) begin
                  if (char_cnt == CW'(k + 1)) begin
                    match_r[k] <= 1'b0;
                  end
                end
              end
            end
`endif
            else if (char_cnt < PW_LEN_C) begin
              for (int k = 0; k < PW_LEN; k++) begin
                if (char_cnt == CW'(k)) begin
                  match_r[k] <= (rx_byte == pw_char(k));
                end
              end
              char_cnt <= char_cnt + 1'b1;
            end else begin
              overflow_r <= 1'b1;
            end
          end
        end
        ST_UNLOCKED: begin
          if (rx_valid && (rx_byte == RELOCK_CHAR)) begin
            state_r <= ST_COLLECT;
            unlock  <= 1'b0;
          end
        end
        ST_LOCKOUT: begin
          if (timer_r == {TW{1'b0}}) begin
            state_r    <= ST_COLLECT;
            locked_out <= 1'b0;
            fail_cnt   <= {FW{1'b0}};
          end else begin
            timer_r <= timer_r - 1'b1;
          end
        end
        default: begin
          state_r    <= ST_COLLECT;
          unlock     <= 1'b0;
          locked_out <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_pw_lock.sv
// Self-checking bench for uart_pw_lock. The bench uses PW_LEN=4, PASSWORD "1234",
// MAX_FAIL=3 and LOCK_CYCLES=16. A queue-based reference model of the
// password rules predicts every output after every clock edge.
module tb_uart_pw_lock;

  logic       clkin = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       unlock, fail_pulse, locked_out;
  logic [2:0] char_cnt;
  logic [1:0] fail_cnt;

  int n_cmp = 0;
  int n_bad = 0;
  int hi_cnt = 0;

  // Reference model state.
  logic [7:0] q[$];
  bit         m_unl;
  int         m_lock;
  int         m_fails;
  bit         m_pulse;
  logic [7:0] pw[4] = '{8'h31, 8'h32, 8'h33, 8'h34};

  uart_pw_lock #(
    .PW_LEN(4), .PASSWORD(32'h31323334), .TERM_CHAR(8'h0D),
    .RELOCK_CHAR(8'h1B), .MAX_FAIL(3), .LOCK_CYCLES(16)
  ) dut (
    .clkin(clkin), .rst_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid),
    .unlock(unlock), .fail_pulse(fail_pulse), .locked_out(locked_out),
    .char_cnt(char_cnt), .fail_cnt(fail_cnt)
  );

  always #5 clkin = ~clkin;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Apply the password rules to one clock edge.
  task automatic model(input logic v, input logic [7:0] b);
    bit ok;
    m_pulse = 1'b0;
    if (!rst_n) begin
      q.delete(); m_unl = 1'b0; m_lock = 0; m_fails = 0;
    end else if (m_lock > 0) begin
      m_lock--;
      if (m_lock == 0) m_fails = 0;
    end else if (m_unl) begin
      if (v && b == 8'h1B) m_unl = 1'b0;
    end else if (v) begin
      if (b == 8'h0D) begin
        ok = (q.size() == 4);
        for (int i = 0; i < 4; i++) if (ok && q[i] != pw[i]) ok = 1'b0;
        q.delete();
        if (ok) begin
          m_unl = 1'b1; m_fails = 0;
        end else begin
          m_pulse = 1'b1; m_fails++;
          if (m_fails == 3) m_lock = 16;
        end
      end
`ifdef UART_PW_BACKSPACE_EN
      else if (b == 8'h08) begin
        if (q.size() > 0 && q.size() <= 4) void'(q.pop_back());
      end
`endif
      else if (q.size() < 5) begin
        q.push_back(b);
      end
    end
  endtask

  task automatic step(input logic v, input logic [7:0] b);
    int cc;
    rx_valid = v;
    rx_byte  = b;
    @(posedge clkin);
    model(v, b);
    #1;
    if (locked_out === 1'b1) hi_cnt++;
    cc = (q.size() > 4) ? 4 : q.size();
    check("unlock", 32'(unlock), 32'(m_unl));
    check("fail_pulse", 32'(fail_pulse), 32'(m_pulse));
    check("locked_out", 32'(locked_out), 32'(m_lock > 0));
    check("char_cnt", 32'(char_cnt), 32'(cc));
    check("fail_cnt", 32'(fail_cnt), 32'(m_fails));
    rx_valid = 1'b0;
  endtask

  task automatic send(input logic [7:0] b);
    step(1'b1, b);
  endtask

  task automatic send_pw();
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h0D);
  endtask

  initial begin
    logic [7:0] pool[10] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h39,
                             8'h0D, 8'h1B, 8'h08, 8'h35, 8'h41};
    // Reset
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    step(1'b0, 8'h00);
    check("rst_unlock", 32'(unlock), 32'd0);
    check("rst_locked", 32'(locked_out), 32'd0);
    check("rst_char_cnt", 32'(char_cnt), 32'd0);
    rst_n = 1'b1;
    step(1'b0, 8'h00);

    // Correct password, then relock
    send_pw();
    check("pw_unlock", 32'(unlock), 32'd1);
    check("pw_fail_cnt", 32'(fail_cnt), 32'd0);
    send(8'h1B);
    check("relock_unlock", 32'(unlock), 32'd0);
    check("relock_char_cnt", 32'(char_cnt), 32'd0);

    // Three failures: wrong char, overflow, empty attempt
    send(8'h31); send(8'h32); send(8'h39); send(8'h34); send(8'h0D);
    check("wrong_pulse", 32'(fail_pulse), 32'd1);
    check("wrong_fail_cnt", 32'(fail_cnt), 32'd1);
    step(1'b0, 8'h00);
    check("pulse_one_cycle", 32'(fail_pulse), 32'd0);
    send(8'h31); send(8'h32); send(8'h33); send(8'h34); send(8'h35);
    check("ovf_char_cnt", 32'(char_cnt), 32'd4);
    send(8'h0D);
    check("ovf_fail_cnt", 32'(fail_cnt), 32'd2);
    hi_cnt = 0;
    send(8'h0D);
    check("lock_fail_cnt", 32'(fail_cnt), 32'd3);
    check("lock_locked", 32'(locked_out), 32'd1);

    // Lockout ignores input and lasts exactly 16 cycles
    send_pw();
    check("lock_ignore_unlock", 32'(unlock), 32'd0);
    for (int i = 0; i < 20; i++) step(1'b0, 8'h00);
    check("lock_length", 32'(hi_cnt), 32'd16);
    check("lock_exit_fail_cnt", 32'(fail_cnt), 32'd0);
    send_pw();
    check("post_lock_unlock", 32'(unlock), 32'd1);
    send(8'h1B);

    // Two failures, then success clears the count
    send(8'h0D); send(8'h0D);
    send_pw();
    check("success_clears", 32'(fail_cnt), 32'd0);
    check("success_unlock", 32'(unlock), 32'd1);
    send(8'h1B);
    send(8'h0D);
    check("single_fail", 32'(fail_cnt), 32'd1);
    check("single_no_lock", 32'(locked_out), 32'd0);

    // Mid-attempt reset
    send(8'h31); send(8'h32);
    rst_n = 1'b0;
    step(1'b0, 8'h00);
    rst_n = 1'b1;
    send(8'h33); send(8'h34); send(8'h0D);
    check("midrst_fail_cnt", 32'(fail_cnt), 32'd1);
    check("midrst_unlock", 32'(unlock), 32'd0);

    // Backspace sequence
    send(8'h31); send(8'h32); send(8'h39); send(8'h08);
    send(8'h33); send(8'h34); send(8'h0D);
`ifdef UART_PW_BACKSPACE_EN
    check("bs_unlock", 32'(unlock), 32'd1);
    send(8'h1B);
`else
    check("bs_fail", 32'(fail_cnt), 32'd2);
    check("bs_no_unlock", 32'(unlock), 32'd0);
`endif

    // Randomized traffic
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
        step(1'b0, 8'h00);
        rst_n = 1'b1;
      end else if ($urandom_range(0, 24) == 0) begin
        send_pw();
      end else begin
        step(($urandom_range(0, 3) != 0), pool[$urandom_range(0, 9)]);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_pw_lock.md
Name: uart_pw_lock

Overview:
- Sequential password checker fed by the UART receiver's byte/strobe output.
- Collects ASCII characters up to a terminator and compares them position by position against a parametrised password.
- Drives an unlock level and a fail pulse, and counts failed attempts; after too many failures it enters a timed lockout.
- Parametrised successor to the single-byte password compare: the password length, the password value, the failure limit and the lockout time are all generics.

Parameters:
- PW_LEN, 4: number of password characters (1..16).
- PASSWORD, 32'h31323334: PW_LEN*8 bits, ASCII "1234"; character 0 is in the most significant byte.
- TERM_CHAR, 8'h0D: terminator byte that triggers evaluation.
- RELOCK_CHAR, 8'h1B: byte that returns the block from UNLOCKED to COLLECT.
- MAX_FAIL, 3: consecutive failures that trigger lockout (at least 1).
- LOCK_CYCLES, 100000000: lockout duration in clkin cycles (at least 1).

Ports:
- clkin, input, 1: system clock; all logic is on the rising edge.
- rst_n, input, 1: synchronous active-low reset.
- rx_byte, input, 8: received byte, valid only when rx_valid=1.
- rx_valid, input, 1: one-cycle strobe per received byte.
- unlock, output, 1: high while in UNLOCKED.
- fail_pulse, output, 1: one-cycle pulse on each failed evaluation.
- locked_out, output, 1: high while in LOCKOUT.
- char_cnt, output, $clog2(PW_LEN+1): characters collected in the current attempt; saturates at PW_LEN.
- fail_cnt, output, $clog2(MAX_FAIL+1): consecutive failures so far.

Behaviour:
- Reset (rst_n=0 at an edge) forces the following, regardless of state or any in-flight attempt:
  - state=COLLECT;
  - unlock=0, fail_pulse=0, locked_out=0;
  - char_cnt=0, fail_cnt=0;
  - match vector=0, overflow=0, lock timer=0.
- All outputs are registered. Every response appears on the edge that samples the rx_valid strobe, so it is visible one cycle later.
- COLLECT state, on rx_valid with rx_byte==TERM_CHAR (evaluation):
  - pass condition: char_cnt==PW_LEN, all PW_LEN match bits set, and overflow=0.
  - on pass: go to UNLOCKED and clear fail_cnt.
  - on fail: fail_pulse=1 for one cycle and fail_cnt+1. If the new fail_cnt equals MAX_FAIL, go to LOCKOUT, load the timer with LOCK_CYCLES-1, and set locked_out=1.
  - in both cases clear char_cnt, the match vector and overflow.
  - a terminator with char_cnt=0 is a failure.
- COLLECT state, on rx_valid with any other byte:
  - if char_cnt<PW_LEN: match[char_cnt] = (rx_byte == PASSWORD character char_cnt), then char_cnt+1.
  - else: overflow=1 and char_cnt holds at PW_LEN.
- UNLOCKED state:
  - unlock=1.
  - rx_valid with RELOCK_CHAR returns to COLLECT with unlock=0 on the next cycle.
  - all other bytes are ignored, and no counters change.
- LOCKOUT state:
  - every byte is ignored, including TERM_CHAR.
  - the timer decrements each cycle; when it reaches 0 the block goes to COLLECT, clears fail_cnt and drops locked_out. Lockout lasts exactly LOCK_CYCLES cycles.
- A successful evaluation resets fail_cnt, so failures must be consecutive to cause lockout.
- fail_cnt never exceeds MAX_FAIL.
- rx_valid held high for several cycles counts as one byte per cycle. No edge detection is required of the source.
- The timer width is $clog2(LOCK_CYCLES).
- The compare is an exact 8-bit match: no case folding, no parity handling.

Optional Feature:
- Macro: UART_PW_BACKSPACE_EN.
- When defined, in COLLECT a byte 8'h08 is handled as follows:
  - if overflow=0 and char_cnt>0: char_cnt-1 and clear match[char_cnt-1].
  - if char_cnt=0: ignored.
  - if overflow=1: ignored; overflow stays set until the next evaluation.
  - 8'h08 never sets a match bit.
- When not defined, 8'h08 is an ordinary character compared against the password.

Test Plan (PW_LEN=4, PASSWORD "1234", MAX_FAIL=3, LOCK_CYCLES=16):
- Reset release, then bytes 31,32,33,34,0D (hex) -> unlock=1 one cycle after the 0D strobe; fail_cnt=0; then byte 1B -> unlock=0 next cycle, char_cnt=0.
- Bytes 31,32,39,34,0D -> one fail_pulse, fail_cnt=1, unlock=0. Bytes 31,32,33,34,35,0D (overflow) -> fail, fail_cnt=2. A lone 0D -> fail, fail_cnt=3 and locked_out=1.
- During lockout, send 31,32,33,34,0D -> all ignored, no fail_pulse. locked_out stays high exactly 16 cycles, then drops with fail_cnt=0, and the correct password then unlocks.
- Two failures, then the correct password -> unlock and fail_cnt=0. One further failure -> fail_cnt=1, not a lockout.
- Mid-attempt reset: send 31,32, assert rst_n=0 for one edge, then send 33,34,0D -> fail (char_cnt was 0 after reset); fail_cnt=1.
- With UART_PW_BACKSPACE_EN: bytes 31,32,39,08,33,34,0D -> unlock=1. Without the macro, the same sequence -> fail.
